// File: rtl/op_arbiter.sv
// op_arbiter: round-robin share of one registered W-bit operator unit.
// Define OP_ARB_ERR_EN to flag illegal opcodes on o_rsp_err.
module op_arbiter #(
  parameter int W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_req0_valid,
  output logic           o_req0_ready,
  input  logic [2:0]     i_req0_op,
  input  logic [W-1:0]   i_req0_a,
  input  logic [W-1:0]   i_req0_b,
  input  logic           i_req0_c,
  input  logic           i_req1_valid,
  output logic           o_req1_ready,
  input  logic [2:0]     i_req1_op,
  input  logic [W-1:0]   i_req1_a,
  input  logic [W-1:0]   i_req1_b,
  input  logic           i_req1_c,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output logic           o_rsp_id,
  output logic [2*W-1:0] o_rsp_data,
  output logic           o_rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last;
  logic           r_id;
  logic [2:0]     r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_c;
  logic [2*W-1:0] r_rsp_data;
  logic           r_rsp_id;
  logic           w_any;
  logic           w_gnt;
  logic           w_idle;
  logic           w_acc;
  logic [2*W-1:0] w_res;

  assign w_any  = i_req0_valid | i_req1_valid;
  assign w_gnt  = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
  assign w_idle = (r_state == IDLE);
  assign w_acc  = w_idle & w_any;

  // Readies are masked while reset is held, even though state already reads IDLE.
  assign o_req0_ready = w_acc & ~w_gnt & ~i_rst;
  assign o_req1_ready = w_acc & w_gnt & ~i_rst;

  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (i_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_res = '0;
    case (r_op)
      3'b000:  w_res[0]     = (r_a <= r_b);
      3'b001:  w_res[0]     = (|r_a) && (|r_b);
      3'b010:  w_res[W-1:0] = r_a | r_b;
      3'b011:  w_res        = {r_a, r_a};
      3'b100:  w_res[W:0]   = {r_a, r_c};
      default: w_res        = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_id       <= 1'b0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_id   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_last <= w_gnt;
        r_id   <= w_gnt;
        r_op   <= w_gnt ? i_req1_op : i_req0_op;
        r_a    <= w_gnt ? i_req1_a : i_req0_a;
        r_b    <= w_gnt ? i_req1_b : i_req0_b;
        r_c    <= w_gnt ? i_req1_c : i_req0_c;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_res;
        r_rsp_id   <= r_id;
      end
    end
  end

`ifdef OP_ARB_ERR_EN
  logic r_rsp_err;
  logic w_illegal;

  assign w_illegal = r_op[2] & (r_op[1] | r_op[0]);
  assign o_rsp_err = r_rsp_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_err <= w_illegal;
    end
  end
`else
  assign o_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_op_arbiter.sv
// tb_op_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_op_arbiter;
  localparam int W = 4;
`ifdef OP_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
  logic r0, r1, rv, rid, rerr;
  logic [2:0] op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic c0 = 1'b0, c1 = 1'b0;
  logic [2*W-1:0] rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  op_arbiter #(.W(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_op(op0),
    .i_req0_a(a0), .i_req0_b(b0), .i_req0_c(c0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_op(op1),
    .i_req1_a(a1), .i_req1_b(b1), .i_req1_c(c1),
    .o_rsp_valid(rv), .i_rsp_ready(rr), .o_rsp_id(rid),
    .o_rsp_data(rdata), .o_rsp_err(rerr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_res(input logic [2:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    case (op)
      3'd0: return (ua <= ub) ? 8'd1 : 8'd0;
      3'd1: return (ua != 0 && ub != 0) ? 8'd1 : 8'd0;
      3'd2: return 8'(ua | ub);
      3'd3: return 8'(ua * 16 + ua);
      3'd4: return 8'(ua * 2 + int'(c));
      default: return 8'd0;
    endcase
  endfunction

  typedef struct {
    bit         id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [7:0] exp;
    bit         ill;
  } vec_t;

  typedef struct {
    bit         id;
    logic [7:0] data;
    bit         err;
  } rsp_t;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rr = 1'b0;
    #1;
    chk("rst_rsp_valid", rv, 0);
    chk("rst_ready0", r0, 0);
    chk("rst_ready1", r1, 0);
    chk("rst_rsp_id", rid, 0);
    chk("rst_rsp_data", rdata, 0);
    chk("rst_rsp_err", rerr, 0);
    @(negedge clk);
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic drain();
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    if (!v.id) begin
      v0 = 1'b1; v1 = 1'b0; op0 = v.op; a0 = v.a; b0 = v.b; c0 = v.c;
    end else begin
      v1 = 1'b1; v0 = 1'b0; op1 = v.op; a1 = v.a; b1 = v.b; c1 = v.c;
    end
    rr = 1'b1;
    #1;
    k = 0;
    while (!(v.id ? r1 : r0) && k < 8) begin
      @(negedge clk); #1; k++;
    end
    chk($sformatf("vec%0d_ready", idx), v.id ? r1 : r0, 1);
    chk($sformatf("vec%0d_other_ready", idx), v.id ? r0 : r1, 0);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_exec_valid", idx), rv, 0);
    v0 = 1'b0; v1 = 1'b0;
    a0 = 4'($urandom); a1 = 4'($urandom); b0 = 4'($urandom);
    b1 = 4'($urandom); op0 = 3'($urandom); op1 = 3'($urandom);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_rsp_valid", idx), rv, 1);
    chk($sformatf("vec%0d_rsp_data", idx), rdata, v.exp);
    chk($sformatf("vec%0d_rsp_id", idx), rid, v.id);
    chk($sformatf("vec%0d_rsp_err", idx), rerr, ERR_EN & v.ill);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_after_hs", idx), rv, 0);
    @(negedge clk);
  endtask

  vec_t vt[10];
  int   gid[$];
  int   gcyc[$];
  rsp_t q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] sd;
    logic       sid;
    bit         m_last, busy, g, e0, e1, erv;
    int         age;
    rsp_t       rs;

    vt[0] = '{0, 3'b000, 4'b1010, 4'b1101, 1'b0, 8'h01, 0};
    vt[1] = '{0, 3'b001, 4'b1010, 4'b1101, 1'b0, 8'h01, 0};
    vt[2] = '{1, 3'b010, 4'b1010, 4'b1101, 1'b0, 8'h0F, 0};
    vt[3] = '{1, 3'b011, 4'b0101, 4'b0000, 1'b0, 8'h55, 0};
    vt[4] = '{1, 3'b100, 4'b0101, 4'b0000, 1'b1, 8'h0B, 0};
    vt[5] = '{0, 3'b000, 4'b1101, 4'b1010, 1'b0, 8'h00, 0};
    vt[6] = '{0, 3'b001, 4'b0000, 4'b0101, 1'b0, 8'h00, 0};
    vt[7] = '{1, 3'b110, 4'b1111, 4'b1111, 1'b1, 8'h00, 1};
    vt[8] = '{0, 3'b111, 4'b1001, 4'b0110, 1'b1, 8'h00, 1};
    vt[9] = '{1, 3'b000, 4'b1111, 4'b1111, 1'b0, 8'h01, 0};

    do_reset();
    foreach (vt[i]) run_vec(vt[i], i);

    // Continuous contention after reset: 0,1,0,1 three cycles apart.
    do_reset();
    rr = 1'b1; v0 = 1'b1; v1 = 1'b1;
    op0 = 3'b010; op1 = 3'b011; a0 = 4'h3; a1 = 4'h6;
    for (int c = 0; c < 30 && gid.size() < 4; c++) begin
      #1;
      chk("cont_exclusive", r0 & r1, 0);
      if (r0) begin gid.push_back(0); gcyc.push_back(c); end
      if (r1) begin gid.push_back(1); gcyc.push_back(c); end
      @(negedge clk);
    end
    chk("cont_grants", gid.size(), 4);
    foreach (gid[i]) begin
      chk($sformatf("cont_order%0d", i), gid[i], i % 2);
      if (i > 0) chk($sformatf("cont_gap%0d", i), gcyc[i] - gcyc[i-1], 3);
    end
    drain();

    // Response backpressure held for five cycles.
    v0 = 1'b1; v1 = 1'b0; op0 = 3'b010; a0 = 4'hA; b0 = 4'h5; rr = 1'b0;
    #1;
    chk("bp_accept", r0, 1);
    @(posedge clk); #1;
    v1 = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid", rv, 1);
    chk("bp_data", rdata, 8'h0F);
    chk("bp_id", rid, 0);
    sd = rdata; sid = rid;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid%0d", i), rv, 1);
      chk($sformatf("bp_hold_data%0d", i), rdata, sd);
      chk($sformatf("bp_hold_id%0d", i), rid, sid);
      chk($sformatf("bp_hold_rdy%0d", i), {r0, r1}, 2'b00);
    end
    @(negedge clk);
    rr = 1'b1; v0 = 1'b0; v1 = 1'b0;
    #1;
    chk("bp_pre_hs_valid", rv, 1);
    @(posedge clk); #1;
    chk("bp_post_hs_valid", rv, 0);
    @(negedge clk);
    v1 = 1'b1;
    #1;
    chk("bp_idle_next", r1, 1);
    @(negedge clk);
    drain();

    // Reset asserted while an operation sits in EXEC.
    v1 = 1'b1; v0 = 1'b0; op1 = 3'b011; a1 = 4'h3; rr = 1'b1;
    #1;
    chk("rx_accept", r1, 1);
    @(posedge clk); #1;
    rst = 1'b1; v0 = 1'b1;
    #1;
    chk("rx_valid", rv, 0);
    chk("rx_ready", {r0, r1}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rx_no_stale", rv, 0);
    chk("rx_tie_r0", r0, 1);
    chk("rx_tie_r1", r1, 0);
    @(posedge clk); #1;
    chk("rx_exec_no_rsp", rv, 0);
    @(negedge clk);
    drain();

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_last = 1'b1;
    age = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      op0 = 3'($urandom); op1 = 3'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom); c0 = 1'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); c1 = 1'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      #1;
      busy = (q.size() != 0);
      g = (v0 && v1) ? !m_last : v1;
      e0 = !busy && (v0 || v1) && !g;
      e1 = !busy && (v0 || v1) && g;
      erv = busy && age >= 1;
      chk("rnd_ready0", r0, e0);
      chk("rnd_ready1", r1, e1);
      chk("rnd_valid", rv, erv);
      if (erv) begin
        chk("rnd_data", rdata, q[0].data);
        chk("rnd_id", rid, q[0].id);
        chk("rnd_err", rerr, q[0].err);
      end
      @(posedge clk);
      if (e0 || e1) begin
        rs.id   = g;
        rs.data = g ? ref_res(op1, a1, b1, c1) : ref_res(op0, a0, b0, c0);
        rs.err  = ERR_EN && ((g ? op1 : op0) >= 3'd5);
        q.push_back(rs);
        m_last = g;
        age = 0;
      end else if (busy) begin
        if (erv && rr) void'(q.pop_front());
        else age++;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
